// File: rtl/sobel_edge.sv
// sobel_edge
// ----------
// Three-stage pipelined Sobel edge detector operating on a 3x3 pixel window,
// plus per-frame bookkeeping of how many output pixels were classified as edges.
//
// Stream semantics: de_i qualifies the window on a*/b*/c* for exactly the cycle it
// is high; there is no ready/backpressure, every de_i cycle is accepted and the
// result appears on de_o/mag_o/edge_o exactly three cycles later.
//
// Ports
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   de_i              : window valid this cycle
//   vs_i              : frame-start pulse (de_i low); restarts counters, latches thr_i
//   a0..c2            : 3x3 window, row a oldest / c newest, column 0 leftmost
//   thr_i             : threshold candidate, taken only while vs_i is high
//   de_o              : de_i delayed by three cycles
//   mag_o             : saturated |Gx|+|Gy| (0 when de_o is low)
//   edge_o            : mag_o >= latched threshold (0 when de_o is low)
//   frame_done_o      : one-cycle pulse after a frame's last output pixel
//   edge_cnt_o        : edge-pixel count of the most recently completed frame
module sobel_edge #(
    parameter int         COL    = 640,
    parameter int         ROW    = 480,
    parameter logic [7:0] THRESH = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_i,
    input  logic        vs_i,
    input  logic [7:0]  a0,
    input  logic [7:0]  a1,
    input  logic [7:0]  a2,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  c0,
    input  logic [7:0]  c1,
    input  logic [7:0]  c2,
    input  logic [7:0]  thr_i,
    output logic        de_o,
    output logic [7:0]  mag_o,
    output logic        edge_o,
    output logic        frame_done_o,
    output logic [19:0] edge_cnt_o
);

    localparam int            CW       = (COL > 1) ? $clog2(COL) : 1;
    localparam int            RW       = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
    localparam logic [19:0]   CNT_MAX  = 20'hFFFFF;

    // x + 2*y + z on 8-bit inputs never exceeds 1020, so 10 bits hold it exactly.
    function automatic logic [9:0] wsum(input logic [7:0] x, input logic [7:0] y,
                                        input logic [7:0] z);
        return {2'b00, x} + {1'b0, y, 1'b0} + {2'b00, z};
    endfunction

    // Unsigned absolute difference without going through a signed intermediate.
    function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] n);
        return (p >= n) ? (p - n) : (n - p);
    endfunction

    // Stage 1: positive/negative partial sums for both gradient directions
    logic [9:0] px_q, nx_q, py_q, ny_q;
    logic       v1_q;
    // Stage 2: absolute gradients
    logic [9:0] gx_q, gy_q;
    logic       v2_q;
    // Stage 3 combinational: magnitude and saturation
    logic [10:0] sum_s;
    logic [7:0]  sat_s;

    logic [7:0]    thr_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [19:0]   run_cnt;
    logic [19:0]   run_next;
    logic          frame_end;

    always_comb begin
        sum_s = {1'b0, gx_q} + {1'b0, gy_q};
        sat_s = (sum_s > 11'd255) ? 8'hFF : sum_s[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q   <= '0;
            nx_q   <= '0;
            py_q   <= '0;
            ny_q   <= '0;
            v1_q   <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
            v2_q   <= 1'b0;
            de_o   <= 1'b0;
            mag_o  <= '0;
            edge_o <= 1'b0;
        end else begin
            px_q   <= wsum(a2, b2, c2);
            nx_q   <= wsum(a0, b0, c0);
            py_q   <= wsum(c0, c1, c2);
            ny_q   <= wsum(a0, a1, a2);
            v1_q   <= de_i;
            gx_q   <= absdiff(px_q, nx_q);
            gy_q   <= absdiff(py_q, ny_q);
            v2_q   <= v1_q;
            de_o   <= v2_q;
            // Outputs are forced to zero whenever they are not qualified.
            mag_o  <= v2_q ? sat_s : 8'd0;
            edge_o <= v2_q && (sat_s >= thr_q);
        end
    end

    // The frame's last pixel is the one on de_o at the final column/row position.
    // run_next already includes that pixel so the reported count is complete.
    always_comb begin
        frame_end = de_o && (col_q == COL_LAST) && (row_q == ROW_LAST);
        run_next  = run_cnt;
        if (de_o && edge_o && (run_cnt != CNT_MAX)) begin
            run_next = run_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q        <= THRESH;
            col_q        <= '0;
            row_q        <= '0;
            run_cnt      <= '0;
            frame_done_o <= 1'b0;
            edge_cnt_o   <= '0;
        end else begin
            frame_done_o <= frame_end;
            if (frame_end) begin
                edge_cnt_o <= run_next;
            end
            if (vs_i) begin
                thr_q <= thr_i;
            end
            // Frame start wins over counting: a pixel leaving the pipe in the vs_i
            // cycle belongs to no frame and is dropped from the count.
            if (vs_i || frame_end) begin
                col_q   <= '0;
                row_q   <= '0;
                run_cnt <= '0;
            end else if (de_o) begin
                run_cnt <= run_next;
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge
// -------------
// Self-checking bench for sobel_edge on a small 4x2 frame. Expected magnitudes
// come from a plain-integer Sobel reference; frame counts come from counting
// model edge flags per frame.
module tb_sobel_edge;

    localparam int         COL    = 4;
    localparam int         ROW    = 2;
    localparam int         NPIX   = COL * ROW;
    localparam logic [7:0] THRESH = 8'd64;
    localparam logic [71:0] FLAT  = {9{8'd128}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [7:0]  a0 = '0, a1 = '0, a2 = '0, b0 = '0, b1 = '0, b2 = '0, c0 = '0, c1 = '0, c2 = '0;
    logic [7:0]  thr_i = '0;
    logic        de_o;
    logic [7:0]  mag_o;
    logic        edge_o;
    logic        frame_done_o;
    logic [19:0] edge_cnt_o;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    sobel_edge #(.COL(COL), .ROW(ROW), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .de_i(de_i), .vs_i(vs_i),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
        .c0(c0), .c1(c1), .c2(c2), .thr_i(thr_i),
        .de_o(de_o), .mag_o(mag_o), .edge_o(edge_o),
        .frame_done_o(frame_done_o), .edge_cnt_o(edge_cnt_o)
    );

    // ---------------- reference model ----------------
    // Window packing: byte i = a0,a1,a2,b0,b1,b2,c0,c1,c2 for i = 0..8.
    function automatic int ref_mag(input logic [71:0] w);
        int p[9];
        int gx, gy, s;
        for (int i = 0; i < 9; i++) p[i] = int'(w[8*i +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        s = gx + gy;
        return (s > 255) ? 255 : s;
    endfunction

    // Right column (a2, b2, c2) set to v, everything else 0.
    function automatic logic [71:0] col2(input logic [7:0] v);
        logic [71:0] w;
        w = '0;
        w[8*2 +: 8] = v;
        w[8*5 +: 8] = v;
        w[8*8 +: 8] = v;
        return w;
    endfunction

    // Only b2 set: magnitude is 2*v.
    function automatic logic [71:0] b2only(input logic [7:0] v);
        logic [71:0] w;
        w = '0;
        w[8*5 +: 8] = v;
        return w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic de, input logic vs, input logic [7:0] thr,
                         input logic [71:0] w);
        de_i  = de;
        vs_i  = vs;
        thr_i = thr;
        {c2, c1, c0, b2, b1, b0, a2, a1, a0} = w;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), {$urandom, $urandom, 8'($urandom)});
            tick();
            checks++;
            if ({de_o, mag_o, edge_o, frame_done_o, edge_cnt_o} !== 31'd0) begin
                errors++;
                $display("FAIL reset_hold: outputs=%h expected 0", {de_o, mag_o, edge_o, frame_done_o, edge_cnt_o});
            end
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'd0, '0);
        tick();
        checks++;
        if ({de_o, mag_o, edge_o, frame_done_o, edge_cnt_o} !== 31'd0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h expected 0", {de_o, mag_o, edge_o, frame_done_o, edge_cnt_o});
        end
    endtask

    task automatic test_flat();
        drive(1'b0, 1'b1, THRESH, '0); tick();
        drive(1'b1, 1'b0, THRESH, FLAT); tick();
        drive(1'b0, 1'b0, THRESH, '0); tick();
        checks++;
        if (de_o !== 1'b0) begin
            errors++;
            $display("FAIL flat_early: de_o=%b expected 0 two cycles after input", de_o);
        end
        tick();
        checks++;
        if ({de_o, mag_o, edge_o} !== {1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL flat_out: de/mag/edge=%b/%0d/%b expected 1/0/0", de_o, mag_o, edge_o);
        end
        tick();
        checks++;
        if ({de_o, mag_o, edge_o} !== 10'd0) begin
            errors++;
            $display("FAIL idle_zero: de/mag/edge=%b/%0d/%b expected 0/0/0", de_o, mag_o, edge_o);
        end
    endtask

    task automatic test_step();
        drive(1'b0, 1'b1, THRESH, '0); tick();
        drive(1'b1, 1'b0, THRESH, col2(8'd255)); tick();
        drive(1'b0, 1'b0, THRESH, '0); tick();
        tick();
        checks++;
        if ({de_o, mag_o, edge_o} !== {1'b1, 8'd255, 1'b1}) begin
            errors++;
            $display("FAIL step_sat: de/mag/edge=%b/%0d/%b expected 1/255/1", de_o, mag_o, edge_o);
        end
        tick();
    endtask

    task automatic test_threshold();
        logic [7:0] thr;
        for (int t = 0; t < 2; t++) begin
            thr = (t == 0) ? 8'd40 : 8'd41;
            drive(1'b0, 1'b1, thr, '0); tick();
            drive(1'b1, 1'b0, thr, col2(8'd10)); tick();
            drive(1'b0, 1'b0, thr, '0); tick();
            tick();
            checks++;
            if ({de_o, mag_o, edge_o} !== {1'b1, 8'd40, (t == 0)}) begin
                errors++;
                $display("FAIL thr_boundary thr=%0d: de/mag/edge=%b/%0d/%b expected 1/40/%0d",
                         thr, de_o, mag_o, edge_o, (t == 0));
            end
            tick();
        end
    endtask

    task automatic test_mid_thr();
        drive(1'b0, 1'b1, 8'd40, '0); tick();
        for (int k = 0; k < 6; k++) begin
            // thr_i moves above the magnitude mid-frame; the latched 40 must stay.
            drive(k < 4, 1'b0, 8'($urandom_range(41, 255)), col2(8'd10));
            tick();
            if (k >= 2) begin
                checks++;
                if ({de_o, mag_o, edge_o} !== {1'b1, 8'd40, 1'b1}) begin
                    errors++;
                    $display("FAIL mid_thr px%0d: de/mag/edge=%b/%0d/%b expected 1/40/1",
                             k - 2, de_o, mag_o, edge_o);
                end
            end
        end
    endtask

    task automatic test_frame();
        logic [71:0] w_s [8];
        int          m;
        for (int i = 0; i < 8; i++) w_s[i] = (i == 1 || i == 4 || i == 6) ? col2(8'd255) : FLAT;
        drive(1'b0, 1'b1, THRESH, '0); tick();
        for (int k = 0; k < 12; k++) begin
            if (k < 8) drive(1'b1, 1'b0, THRESH, w_s[k]);
            else       drive(1'b0, 1'b0, THRESH, '0);
            tick();
            if (k >= 2 && k < 10) begin
                m = ref_mag(w_s[k-2]);
                checks++;
                if (de_o !== 1'b1 || mag_o !== 8'(m) || edge_o !== (m >= int'(THRESH))) begin
                    errors++;
                    $display("FAIL frame_px%0d: de/mag/edge=%b/%0d/%b expected 1/%0d/%0d",
                             k - 2, de_o, mag_o, edge_o, m, (m >= int'(THRESH)));
                end
            end
            checks++;
            if (frame_done_o !== (k == 10)) begin
                errors++;
                $display("FAIL frame_done k=%0d: got %b expected %0d", k, frame_done_o, (k == 10));
            end
            if (k >= 10) begin
                checks++;
                if (edge_cnt_o !== 20'd3) begin
                    errors++;
                    $display("FAIL frame_cnt k=%0d: got %0d expected 3", k, edge_cnt_o);
                end
            end
        end
    endtask

    task automatic test_vs_inflight();
        logic [71:0] w_s [14];
        logic        de_s [14];
        logic        vs_s [14];
        int          m;
        for (int k = 0; k < 14; k++) begin
            de_s[k] = (k < 3) || (k >= 4 && k < 10);
            vs_s[k] = (k == 3);
            w_s[k]  = (k < 3 || k == 5 || k == 7) ? col2(8'd255) : FLAT;
        end
        drive(1'b0, 1'b1, THRESH, '0); tick();
        for (int k = 0; k < 14; k++) begin
            drive(de_s[k], vs_s[k], THRESH, w_s[k]);
            tick();
            if (k >= 2) begin
                m = de_s[k-2] ? ref_mag(w_s[k-2]) : 0;
                checks++;
                if (de_o !== de_s[k-2] || mag_o !== 8'(m) || edge_o !== (de_s[k-2] && m >= int'(THRESH))) begin
                    errors++;
                    $display("FAIL inflight k=%0d: de/mag/edge=%b/%0d/%b expected %b/%0d/%0d",
                             k, de_o, mag_o, edge_o, de_s[k-2], m, (de_s[k-2] && m >= int'(THRESH)));
                end
            end
            checks++;
            if (frame_done_o !== (k == 12)) begin
                errors++;
                $display("FAIL inflight_done k=%0d: got %b expected %0d", k, frame_done_o, (k == 12));
            end
            if (k == 12) begin
                checks++;
                if (edge_cnt_o !== 20'd4) begin
                    errors++;
                    $display("FAIL inflight_cnt: got %0d expected 4", edge_cnt_o);
                end
            end
        end
    endtask

    task automatic test_vs_at_end();
        logic de;
        int   exp_cnt;
        drive(1'b0, 1'b1, THRESH, '0); tick();
        for (int k = 0; k < 23; k++) begin
            de = (k < 8) || (k >= 11 && k < 19);
            drive(de, (k == 10), THRESH, (k < 8) ? col2(8'd255) : FLAT);
            tick();
            checks++;
            if (frame_done_o !== (k == 10 || k == 21)) begin
                errors++;
                $display("FAIL vs_end_done k=%0d: got %b expected %0d", k, frame_done_o, (k == 10 || k == 21));
            end
            if (k >= 10) begin
                exp_cnt = (k >= 21) ? 0 : 8;
                checks++;
                if (edge_cnt_o !== 20'(exp_cnt)) begin
                    errors++;
                    $display("FAIL vs_end_cnt k=%0d: got %0d expected %0d", k, edge_cnt_o, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic de_s [20];
        logic exp_de;
        drive(1'b0, 1'b1, 8'd100, '0); tick();
        for (int k = 0; k < 20; k++) de_s[k] = (k < 7) || (k >= 7 && k < 15);
        for (int k = 0; k < 20; k++) begin
            rst = (k == 5 || k == 6);
            drive(de_s[k], 1'b0, 8'd100, b2only(8'd40));
            tick();
            if (k == 5 || k == 6) begin
                checks++;
                if ({de_o, mag_o, edge_o, frame_done_o, edge_cnt_o} !== 31'd0) begin
                    errors++;
                    $display("FAIL rst_mid_zero k=%0d: outputs=%h expected 0", k,
                             {de_o, mag_o, edge_o, frame_done_o, edge_cnt_o});
                end
            end else if (k >= 2) begin
                // Before reset the latched 100 applies; after it, THRESH (64) does.
                exp_de = (k < 5) || (k - 2 >= 7 && k - 2 < 15);
                checks++;
                if (de_o !== exp_de || mag_o !== (exp_de ? 8'd80 : 8'd0) || edge_o !== (exp_de && k >= 7)) begin
                    errors++;
                    $display("FAIL rst_mid_px k=%0d: de/mag/edge=%b/%0d/%b expected %b/%0d/%0d", k,
                             de_o, mag_o, edge_o, exp_de, exp_de ? 80 : 0, (exp_de && k >= 7));
                end
                checks++;
                if (frame_done_o !== (k == 17)) begin
                    errors++;
                    $display("FAIL rst_mid_done k=%0d: got %b expected %0d", k, frame_done_o, (k == 17));
                end
                if (k == 17) begin
                    checks++;
                    if (edge_cnt_o !== 20'd8) begin
                        errors++;
                        $display("FAIL rst_mid_cnt: got %0d expected 8", edge_cnt_o);
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [8:0]  exp_q[$];
        int          t_q[$];
        logic [7:0]  thr;
        logic [71:0] w;
        logic [8:0]  e;
        logic        de, done_next, exp_done;
        int          issue, sent, seen, cnt, last_cnt, cyc, m;
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, '0);
        tick();
        rst = 1'b0;
        last_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            thr = 8'($urandom_range(0, 255));
            drive(1'b0, 1'b1, thr, '0);
            tick();
            sent = 0; seen = 0; cnt = 0; cyc = 0; done_next = 1'b0;
            while ((seen < NPIX || done_next) && cyc < 200) begin
                de = (sent < NPIX) && ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 9; i++)
                    w[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20))
                                                               : 8'($urandom_range(0, 255));
                if (de) begin
                    m = ref_mag(w);
                    exp_q.push_back({(m >= int'(thr)), 8'(m)});
                    t_q.push_back(cyc);
                    sent++;
                end
                drive(de, 1'b0, 8'($urandom_range(0, 255)), w);
                tick();
                cyc++;
                exp_done  = done_next;
                done_next = 1'b0;
                if (exp_done) last_cnt = cnt;
                checks++;
                if (frame_done_o !== exp_done) begin
                    errors++;
                    $display("FAIL rnd_done f=%0d cyc=%0d: got %b expected %b", f, cyc, frame_done_o, exp_done);
                end
                checks++;
                if (edge_cnt_o !== 20'(last_cnt)) begin
                    errors++;
                    $display("FAIL rnd_cnt f=%0d cyc=%0d: got %0d expected %0d", f, cyc, edge_cnt_o, last_cnt);
                end
                checks++;
                if (de_o === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_extra f=%0d cyc=%0d: got de_o=1 expected 0", f, cyc);
                    end else begin
                        e     = exp_q.pop_front();
                        issue = t_q.pop_front();
                        if (mag_o !== e[7:0] || edge_o !== e[8] || cyc - issue != 3) begin
                            errors++;
                            $display("FAIL rnd_px f=%0d cyc=%0d: mag/edge/lat=%0d/%b/%0d expected %0d/%b/3",
                                     f, cyc, mag_o, edge_o, cyc - issue, e[7:0], e[8]);
                        end
                        if (e[8]) cnt++;
                        seen++;
                        if (seen == NPIX) done_next = 1'b1;
                    end
                end else if (de_o !== 1'b0 || mag_o !== 8'd0 || edge_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle f=%0d cyc=%0d: de/mag/edge=%b/%0d/%b expected 0/0/0",
                             f, cyc, de_o, mag_o, edge_o);
                end
            end
            checks++;
            if (cyc >= 200 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL rnd_timeout f=%0d: cycles=%0d pending=%0d expected <200/0", f, cyc, exp_q.size());
            end
            exp_q.delete();
            t_q.delete();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_flat();
        test_step();
        test_threshold();
        test_mid_thr();
        test_frame();
        test_vs_inflight();
        test_vs_at_end();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
